// File: rtl/mips_control_unit_if.sv
// rtl/mips_control_unit_if.sv - control unit <-> multicycle datapath bundle
interface mips_control_unit_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic [STATE_W-1:0] state;
  logic               PCEn;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic [1:0]         PCSource;
  logic               Error;

  modport master (
    input  opcode, funct, zero,
    output state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSource, Error
  );

  modport slave (
    output opcode, funct, zero,
    input  state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSource, Error
  );
endinterface

// File: rtl/mips_control_unit.sv
// rtl/mips_control_unit.sv - multicycle MIPS control FSM
module mips_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_control_unit_if.master     bus
);
  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    ALUWB  = STATE_W'(7),
    BRANCH = STATE_W'(8),
    ADDIEX = STATE_W'(9),
    ADDIWB = STATE_W'(10),
    JUMP   = STATE_W'(11),
    ERROR  = STATE_W'(15)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = 3'b010;
    case (bus.funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.PCEn       = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 3'b010;
    bus.PCSource   = 2'b00;
    bus.Error      = 1'b0;
    case (r_state)
      FETCH: begin
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCEn    = 1'b1;
        w_next      = DECODE;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:   w_next = MEMADR;
          OP_RTYPE:       w_next = w_funct_ok ? EXEC : ERROR;
          OP_BEQ, OP_BNE: w_next = BRANCH;
          OP_ADDI:        w_next = ADDIEX;
          OP_J:           w_next = JUMP;
          default:        w_next = ERROR;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.IorD = 1'b1;
        w_next   = MEMWB;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        w_next       = FETCH;
      end
      EXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = w_funct_alu;
        w_next         = ALUWB;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        w_next       = FETCH;
      end
      // Branch target already sits in ALUOut from DECODE; the ALU only compares here
      BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = 3'b110;
        bus.PCSource   = 2'b01;
        bus.PCEn       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        w_next         = FETCH;
      end
      ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = ADDIWB;
      end
      ADDIWB: begin
        bus.RegWrite = 1'b1;
        w_next       = FETCH;
      end
      JUMP: begin
        bus.PCSource = 2'b10;
        bus.PCEn     = 1'b1;
        w_next       = FETCH;
      end
      ERROR: begin
        bus.Error = 1'b1;
        w_next    = ERROR;
      end
      default: w_next = ERROR;
    endcase
    // Reset wins over any in-flight write so an abandoned instruction commits nothing
    if (rst) begin
      bus.PCEn     = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end

  assign bus.state = r_state;
endmodule
